// File: rtl/lvt_pkg.sv
// Shared types and helpers for the LVT replica allocator: FSM states,
// modulo-R replica arithmetic and the write-port/replica-count check.
package lvt_pkg;

  typedef enum logic {
    SWEEP = 1'b0,
    IDLE  = 1'b1
  } lvt_state_e;

  function automatic int unsigned replica_inc(input int unsigned cur, input int unsigned r);
    return (cur == r - 32'd1) ? 32'd0 : cur + 32'd1;
  endfunction

  // base is always below r and k never exceeds r-1, so one subtraction suffices
  function automatic int unsigned replica_add(input int unsigned base, input int unsigned k,
                                              input int unsigned r);
    return (base + k >= r) ? base + k - r : base + k;
  endfunction

  function automatic bit ports_fit(input int unsigned w_ports, input int unsigned r);
    return w_ports <= r;
  endfunction

endpackage

// File: rtl/lvt_port_rank.sv
// Per-port rank among earlier same-address writers and a flag marking the
// highest-numbered enabled port on each address (the one that updates the entry).
module lvt_port_rank #(
  parameter int INDEX_WIDTH = 8,
  parameter int N_BITS_R    = 2,
  parameter int W_PORTS     = 2
) (
  input  logic [W_PORTS-1:0]             w_en,
  input  logic [W_PORTS*INDEX_WIDTH-1:0] w_addr,
  output logic [W_PORTS*N_BITS_R-1:0]    rank,
  output logic [W_PORTS-1:0]             last_writer
);

  always_comb begin
    int cnt;
    cnt = 0;
    rank = '0;
    last_writer = '0;
    for (int i = 0; i < W_PORTS; i++) begin
      cnt = 0;
      last_writer[i] = w_en[i];
      for (int j = 0; j < W_PORTS; j++) begin
        if (w_en[j] && (w_addr[j*INDEX_WIDTH +: INDEX_WIDTH] == w_addr[i*INDEX_WIDTH +: INDEX_WIDTH])) begin
          if (j < i) cnt = cnt + 1;
          if (j > i) last_writer[i] = 1'b0;
        end
      end
      rank[i*N_BITS_R +: N_BITS_R] = N_BITS_R'(cnt);
    end
  end

endmodule

// File: rtl/lvt_replica_allocator.sv
// LVT replica allocator: tracks the last replica written per table index and
// hands each write port a distinct replica. Optional lookup forwarding: LVT_ALLOC_BYPASS_EN.
module lvt_replica_allocator
  import lvt_pkg::*;
#(
  parameter int INDEX_WIDTH = 8,
  parameter int R           = 4,
  parameter int N_BITS_R    = 2,
  parameter int W_PORTS     = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           init,
  output logic                           ready,
  input  logic [W_PORTS-1:0]             w_en,
  input  logic [W_PORTS*INDEX_WIDTH-1:0] w_addr,
  output logic [W_PORTS*N_BITS_R-1:0]    w_index,
  output logic [W_PORTS-1:0]             w_ack,
  input  logic [INDEX_WIDTH-1:0]         rd_addr,
  output logic [N_BITS_R-1:0]            rd_index,
  output logic                           rd_valid
);

  localparam int DEPTH = 2 ** INDEX_WIDTH;

  if (!ports_fit(W_PORTS, R) || R < 2 || R > 2 ** N_BITS_R) begin : g_param_check
    $error("lvt_replica_allocator: need W_PORTS <= R and 2 <= R <= 2**N_BITS_R");
  end

  lvt_state_e                  state;
  logic [INDEX_WIDTH-1:0]      sweep_ptr;
  logic                        entry_valid [DEPTH];
  logic [N_BITS_R-1:0]         entry_last  [DEPTH];
  logic [W_PORTS*N_BITS_R-1:0] rank;
  logic [W_PORTS-1:0]          last_writer;
  logic [W_PORTS*N_BITS_R-1:0] alloc;
  logic                        accept;
  logic                        look_valid;
  logic [N_BITS_R-1:0]         look_index;

  lvt_port_rank #(
    .INDEX_WIDTH(INDEX_WIDTH),
    .N_BITS_R   (N_BITS_R),
    .W_PORTS    (W_PORTS)
  ) u_port_rank (
    .w_en       (w_en),
    .w_addr     (w_addr),
    .rank       (rank),
    .last_writer(last_writer)
  );

  assign accept = (state == IDLE) && !init;

  always_comb begin
    logic [INDEX_WIDTH-1:0] idx;
    int unsigned            base;
    idx = '0;
    base = 0;
    alloc = '0;
    for (int i = 0; i < W_PORTS; i++) begin
      idx = w_addr[i*INDEX_WIDTH +: INDEX_WIDTH];
      base = entry_valid[idx] ? replica_inc(32'(entry_last[idx]), R) : 32'd0;
      alloc[i*N_BITS_R +: N_BITS_R] = N_BITS_R'(replica_add(base, 32'(rank[i*N_BITS_R +: N_BITS_R]), R));
    end
  end

  always_comb begin
    look_valid = entry_valid[rd_addr];
    look_index = entry_last[rd_addr];
`ifdef LVT_ALLOC_BYPASS_EN
    // ascending loop leaves the highest-numbered matching port's allocation in place
    if (accept) begin
      for (int i = 0; i < W_PORTS; i++) begin
        if (w_en[i] && (w_addr[i*INDEX_WIDTH +: INDEX_WIDTH] == rd_addr)) begin
          look_valid = 1'b1;
          look_index = alloc[i*N_BITS_R +: N_BITS_R];
        end
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= SWEEP;
      sweep_ptr <= '0;
      ready     <= 1'b0;
      w_ack     <= '0;
      w_index   <= '0;
      rd_index  <= '0;
      rd_valid  <= 1'b0;
    end else begin
      w_ack    <= '0;
      w_index  <= '0;
      rd_index <= '0;
      rd_valid <= 1'b0;
      case (state)
        SWEEP: begin
          sweep_ptr <= sweep_ptr + 1'b1;
          if (&sweep_ptr) begin
            state <= IDLE;
            ready <= 1'b1;
          end
        end
        IDLE: begin
          rd_valid <= look_valid;
          rd_index <= look_index;
          if (init) begin
            state     <= SWEEP;
            sweep_ptr <= '0;
            ready     <= 1'b0;
          end else begin
            w_ack   <= w_en;
            w_index <= alloc;
          end
        end
        default: state <= SWEEP;
      endcase
    end
  end

  // Table has no reset; the sweep clears it, which also keeps it BRAM/LUTRAM friendly
  always_ff @(posedge clk) begin
    if (state == SWEEP) begin
      entry_valid[sweep_ptr] <= 1'b0;
      entry_last[sweep_ptr]  <= '0;
    end else if (accept) begin
      for (int i = 0; i < W_PORTS; i++) begin
        if (last_writer[i]) begin
          entry_valid[w_addr[i*INDEX_WIDTH +: INDEX_WIDTH]] <= 1'b1;
          entry_last[w_addr[i*INDEX_WIDTH +: INDEX_WIDTH]]  <= alloc[i*N_BITS_R +: N_BITS_R];
        end
      end
    end
  end

endmodule

// File: tb/tb_lvt_replica_allocator.sv
// Self-checking bench for lvt_replica_allocator (INDEX_WIDTH=4, R=4, 2 ports)
// against a table-level model; honours LVT_ALLOC_BYPASS_EN.
module tb_lvt_replica_allocator;

  localparam int IW    = 4;
  localparam int R     = 4;
  localparam int NB    = 2;
  localparam int WP    = 2;
  localparam int DEPTH = 2 ** IW;

`ifdef LVT_ALLOC_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              init;
  logic              ready;
  logic [WP-1:0]     w_en;
  logic [WP*IW-1:0]  w_addr;
  logic [WP*NB-1:0]  w_index;
  logic [WP-1:0]     w_ack;
  logic [IW-1:0]     rd_addr;
  logic [NB-1:0]     rd_index;
  logic              rd_valid;

  lvt_replica_allocator #(
    .INDEX_WIDTH(IW),
    .R          (R),
    .N_BITS_R   (NB),
    .W_PORTS    (WP)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .init    (init),
    .ready   (ready),
    .w_en    (w_en),
    .w_addr  (w_addr),
    .w_index (w_index),
    .w_ack   (w_ack),
    .rd_addr (rd_addr),
    .rd_index(rd_index),
    .rd_valid(rd_valid)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int failures = 0;

  bit m_ready;
  int m_sweep;
  bit mv [DEPTH];
  int ml [DEPTH];

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_ready"}, 32'(ready), 0);
    check_output({tag, "_w_ack"}, 32'(w_ack), 0);
    check_output({tag, "_w_index"}, 32'(w_index), 0);
    check_output({tag, "_rd_index"}, 32'(rd_index), 0);
    check_output({tag, "_rd_valid"}, 32'(rd_valid), 0);
  endtask

  task automatic model_reset();
    m_ready = 1'b0;
    m_sweep = 0;
  endtask

  // One clock of stimulus; the model predicts, then the outputs are checked after the edge
  task automatic apply_stimulus(input logic [WP-1:0] en, input logic [IW-1:0] a0,
                                input logic [IW-1:0] a1, input logic [IW-1:0] ra, input bit ini);
    logic [IW-1:0] addr [WP];
    int  alloc [WP];
    bit  exp_ack [WP];
    bit  exp_rv;
    int  exp_ri;
    int  k, base;
    addr[0] = a0;
    addr[1] = a1;
    w_en = en;
    w_addr = {a1, a0};
    rd_addr = ra;
    init = ini;
    for (int i = 0; i < WP; i++) begin
      k = 0;
      for (int j = 0; j < i; j++)
        if (en[j] && addr[j] == addr[i]) k++;
      base = mv[addr[i]] ? (ml[addr[i]] + 1) % R : 0;
      alloc[i] = (base + k) % R;
      exp_ack[i] = m_ready && !ini && en[i];
    end
    exp_rv = 1'b0;
    exp_ri = 0;
    if (m_ready) begin
      exp_rv = mv[ra];
      exp_ri = ml[ra];
      if (BYPASS && !ini)
        for (int i = 0; i < WP; i++)
          if (en[i] && addr[i] == ra) begin
            exp_rv = 1'b1;
            exp_ri = alloc[i];
          end
    end
    if (!m_ready) begin
      mv[m_sweep] = 1'b0;
      ml[m_sweep] = 0;
      m_sweep++;
      if (m_sweep == DEPTH) m_ready = 1'b1;
    end else if (ini) begin
      m_ready = 1'b0;
      m_sweep = 0;
    end else begin
      for (int i = 0; i < WP; i++)
        if (en[i]) begin
          mv[addr[i]] = 1'b1;
          ml[addr[i]] = alloc[i];
        end
    end
    @(posedge clk);
    #1;
    check_output("ready", 32'(ready), 32'(m_ready));
    for (int i = 0; i < WP; i++) begin
      check_output($sformatf("w_ack%0d", i), 32'(w_ack[i]), 32'(exp_ack[i]));
      if (exp_ack[i])
        check_output($sformatf("w_index%0d", i), 32'(w_index[i*NB +: NB]), 32'(alloc[i]));
    end
    check_output("rd_valid", 32'(rd_valid), 32'(exp_rv));
    if (exp_rv) check_output("rd_index", 32'(rd_index), 32'(exp_ri));
  endtask

  initial begin
    int seq [5];
    seq = '{0, 1, 2, 3, 0};
    reset = 1'b0;
    init = 1'b0;
    w_en = '0;
    w_addr = '0;
    rd_addr = '0;
    for (int i = 0; i < DEPTH; i++) begin
      mv[i] = 1'b0;
      ml[i] = 0;
    end
    model_reset();

    #12;
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    reset = 1'b1;

    // sweep: writes dropped, lookups invalid, ready rises on the 16th edge
    for (int c = 0; c < DEPTH; c++)
      apply_stimulus(WP'($urandom), IW'($urandom), IW'($urandom), IW'(c), 1'b0);
    check_output("tp_ready_after_sweep", 32'(ready), 1);
    for (int c = 0; c < DEPTH; c++)
      apply_stimulus('0, '0, '0, IW'(c), 1'b0);

    for (int n = 0; n < 5; n++) begin
      apply_stimulus(2'b01, 4'd3, 4'd0, 4'd0, 1'b0);
      check_output("tp_addr3_seq", 32'(w_index[1:0]), 32'(seq[n]));
    end
    apply_stimulus('0, '0, '0, 4'd3, 1'b0);
    check_output("tp_addr3_rd_index", 32'(rd_index), 0);
    check_output("tp_addr3_rd_valid", 32'(rd_valid), 1);

    apply_stimulus(2'b11, 4'd5, 4'd5, 4'd0, 1'b0);
    check_output("tp_same_addr_p0", 32'(w_index[1:0]), 0);
    check_output("tp_same_addr_p1", 32'(w_index[3:2]), 1);
    apply_stimulus(2'b01, 4'd5, 4'd0, 4'd0, 1'b0);
    check_output("tp_same_addr_next", 32'(w_index[1:0]), 2);

    apply_stimulus(2'b11, 4'd7, 4'd9, 4'd7, 1'b0);
    check_output("tp_diff_addr_ack", 32'(w_ack), 3);
    check_output("tp_diff_addr_idx", 32'(w_index), 0);
    apply_stimulus('0, '0, '0, 4'd9, 1'b0);
    check_output("tp_addr9_valid", 32'(rd_valid), 1);

    apply_stimulus(2'b01, 4'd4, 4'd0, 4'd0, 1'b1);
    check_output("tp_init_ack", 32'(w_ack), 0);
    check_output("tp_init_ready", 32'(ready), 0);
    for (int c = 0; c < DEPTH; c++)
      apply_stimulus('0, '0, '0, IW'($urandom), 1'b0);
    apply_stimulus('0, '0, '0, 4'd3, 1'b0);
    check_output("tp_addr3_cleared", 32'(rd_valid), 0);

    apply_stimulus(2'b01, 4'd2, 4'd0, 4'd2, 1'b0);
    check_output("tp_bypass_valid", 32'(rd_valid), 32'(BYPASS));
    check_output("tp_bypass_index", 32'(rd_index), 0);

    // randomized traffic on a narrow address range to force collisions
    for (int n = 0; n < 300; n++)
      apply_stimulus(WP'($urandom), IW'($urandom_range(0, 3)), IW'($urandom_range(0, 3)),
                     IW'($urandom_range(0, 3)), ($urandom_range(0, 29) == 0));

    for (int n = 0; n <= DEPTH && !m_ready; n++)
      apply_stimulus('0, '0, '0, '0, 1'b0);
    apply_stimulus(2'b11, 4'd1, 4'd2, 4'd1, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs("reset_mid_write");
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int c = 0; c < 5; c++)
      apply_stimulus(WP'($urandom), IW'($urandom), IW'($urandom), IW'(c), 1'b0);
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs("reset_mid_sweep");
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int c = 0; c < DEPTH; c++)
      apply_stimulus('0, '0, '0, IW'(c), 1'b0);
    for (int n = 0; n < 40; n++)
      apply_stimulus(WP'($urandom), IW'($urandom_range(0, 3)), IW'($urandom_range(0, 3)),
                     IW'($urandom_range(0, 3)), 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/lvt_replica_allocator.md
# lvt_replica_allocator

Multi-port replica allocator for the live-value-table (LVT) memory. For every table index it tracks the last BRAM replica written and whether the entry has ever been written. Each cycle it hands each active write port a distinct replica index, including when several ports hit the same index in one cycle. It sits between the write-port arbiter and the replicated BRAM banks and clears its table with a sweep state machine instead of a reset loop.

## Interface
- INDEX_WIDTH, 8, table index width; table depth 2**INDEX_WIDTH
- R, 4, replica count; legal range 2..2**N_BITS_R
- N_BITS_R, 2, replica-index width
- W_PORTS, 2, write-port count; must satisfy W_PORTS <= R (elaboration error otherwise)

- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- init  in  1  pulse: restart the clear sweep
- ready  out  1  high when writes are accepted (state IDLE)
- w_en  in  W_PORTS  per-port write request
- w_addr  in  W_PORTS*INDEX_WIDTH  port i at [i*INDEX_WIDTH +: INDEX_WIDTH]
- w_index  out  W_PORTS*N_BITS_R  registered allocated replica, port i at [i*N_BITS_R +: N_BITS_R]
- w_ack  out  W_PORTS  registered: w_index for port i is valid this cycle
- rd_addr  in  INDEX_WIDTH  lookup index
- rd_index  out  N_BITS_R  registered last-written replica for rd_addr
- rd_valid  out  1  registered valid bit for rd_addr

## Operation
- Storage per entry: valid bit and last[N_BITS_R]. Next replica for an entry = valid ? (last==R-1 ? 0 : last+1) : 0.
- FSM states: SWEEP and IDLE. Reset enters SWEEP with sweep pointer 0.
- In SWEEP, one entry is cleared per cycle (valid=0, last=0) at pointer p. Exit to IDLE after entry 2**INDEX_WIDTH-1 is cleared. Every entry is cleared, including the last one.
- In IDLE with init=1: go to SWEEP with p=0. Writes presented in that cycle are dropped (w_ack=0). init is ignored while in SWEEP.
- In IDLE, port i with w_en[i] is accepted. Rank k_i = number of ports j<i with w_en[j] and w_addr[j]==w_addr[i].
  - Port i is allocated base+k_i wrapped modulo R, where base is the entry's next replica.
- Entry update: the highest-numbered accepted port on an address writes last = its allocated index and sets valid=1. Lower-ranked same-address ports do not write the entry.
- w_en while not ready: dropped, w_ack=0, no table change.
- Lookup returns the entry state before same-cycle writes, unless the bypass is enabled (see Configuration). During SWEEP, rd_valid=0.

## Timing
- Reset values: ready=0, w_ack=0, w_index=0, rd_index=0, rd_valid=0. FSM=SWEEP, p=0.
- Sweep: ready rises 2**INDEX_WIDTH cycles after the first clk edge with reset high.
- Write latency: 1 cycle. w_ack and w_index are registered at the edge that samples w_en. A following-cycle write to the same address sees the updated entry (back-to-back safe).
- Lookup latency: 1 cycle.
- Reset asserted mid-sweep or mid-write: all outputs return to reset values immediately, and the sweep restarts from 0.

## Configuration
- LVT_ALLOC_BYPASS_EN defined: the lookup forwards same-cycle accepted writes. If any accepted port targets rd_addr, rd_index is the highest-numbered such port's allocated index and rd_valid=1.
- LVT_ALLOC_BYPASS_EN undefined: the lookup reflects pre-write table state only.

## Structure
- Package lvt_pkg: FSM state enum (SWEEP, IDLE), the replica wrap function (modulo R increment), and the W_PORTS<=R check constant.
- Sub-module lvt_port_rank: combinational. From w_en/w_addr it computes each port's rank k_i and a last-writer flag per port.
- The table is a register array in the top block.

## Test plan
- Reset, INDEX_WIDTH=4 -> ready=0 for 16 cycles, then 1. rd_valid=0 for all 16 addresses.
- Port0 writes addr 3 for five consecutive cycles (R=4) -> w_index 0,1,2,3,0. Next-cycle lookup of addr 3 gives rd_index=0, rd_valid=1.
- Port0 and port1 both write addr 5 in one cycle (fresh entry) -> w_index 0 and 1. Next write to addr 5 gets 2.
- Ports write addrs 7 and 9 in one cycle -> both w_index=0, both w_ack=1, both entries valid.
- init pulsed together with w_en[0] in IDLE -> w_ack=0, ready=0 next cycle. After the sweep, the previously written addr 3 reads rd_valid=0.
- Lookup and write of addr 2 in the same cycle -> with LVT_ALLOC_BYPASS_EN, rd_valid=1 and rd_index=0; without it, rd_valid=0.
